sched_arbiter: RTL and testbench
================================

SCHED_ARBITER -- requirements
Module: sched_arbiter

Interface
REQ-001 Parameter TIMEOUT, default 80: maximum WAIT-state cycles before abort; legal range 65..255.
REQ-002 Port clk  input  1  system clock; all state updates on rising edge.
REQ-003 Port reset  input  1  synchronous, active-high reset.
REQ-004 Port req0_valid  input  1  requester 0 has a block pending.
REQ-005 Port req0_block  input  512  requester 0 message block, word 0 in bits [511:480].
REQ-006 Port req0_count  input  2  requester 0 block count, forwarded to the scheduler.
REQ-007 Port req0_ready  output  1  one-cycle pulse: requester 0 block accepted this cycle.
REQ-008 Ports req1_valid, req1_block, req1_count, req1_ready: same widths and meanings as requester 0.
REQ-009 Port sched_start  output  1  one-cycle pulse that restarts the message scheduler.
REQ-010 Port sched_block  output  512  latched block driven to the scheduler.
REQ-011 Port sched_block_count  output  2  latched block count driven to the scheduler.
REQ-012 Port sched_done  input  1  scheduler has produced all 64 words.
REQ-013 Port resp_valid  output  1  one-cycle pulse: current job finished.
REQ-014 Port resp_id  output  1  requester index of the finished job; valid with resp_valid.
REQ-015 Port resp_err  output  1  job aborted by timeout; valid with resp_valid.
REQ-016 Port busy  output  1  high in every state except IDLE.

Function
REQ-017 FSM states IDLE, START, WAIT, RESP; one job in flight at most.
REQ-018 IDLE: if any reqN_valid, grant one requester, latch its block/count, pulse its reqN_ready, go to START; else stay.
REQ-019 Arbitration round-robin: when both valid, grant the requester not granted last; single valid requester always wins.
REQ-020 START lasts exactly one cycle with sched_start=1, then WAIT.
REQ-021 sched_done sampled only in WAIT; sched_done high in IDLE/START/RESP ignored.
REQ-022 WAIT: sched_done=1 -> RESP with resp_err=0 on next cycle.
REQ-023 RESP lasts one cycle: resp_valid=1, resp_id=granted index; then IDLE.
REQ-024 Latency: accept at cycle T, sched_start at T+1, WAIT from T+2; sched_done at cycle D gives resp_valid at D+1; next accept earliest D+2.
REQ-025 sched_block and sched_block_count held stable from accept until the next accept; never change mid-job.
REQ-026 reqN_ready never asserted outside IDLE; never both reqN_ready high in one cycle.
REQ-027 Requester dropping reqN_valid after accept has no effect on the running job.

Reset
REQ-028 reset has priority over all events, including a simultaneous sched_done or reqN_valid.
REQ-029 After reset: state IDLE, last-grant pointer = 1 (requester 0 wins first tie), sched_block = 0, sched_block_count = 0, timeout counter = 0.
REQ-030 During and after reset: req0_ready, req1_ready, sched_start, resp_valid, resp_id, resp_err, busy all 0.
REQ-031 Reset mid-job abandons the job without a resp_valid pulse.

Configuration
REQ-032 Macro SCHED_TIMEOUT_EN: when defined, an 8-bit counter clears on WAIT entry and increments each WAIT cycle; reaching TIMEOUT without sched_done forces RESP with resp_err=1.
REQ-033 Simultaneous sched_done and terminal count: done wins, resp_err=0.
REQ-034 Without SCHED_TIMEOUT_EN: no counter, WAIT lasts until sched_done, resp_err tied to 0.

Verification
REQ-035 Only req0_valid=1, count=1, block=0x61626380_0..0_00000018; sched_done 64 cycles after sched_start -> req0_ready cycle T, sched_start T+1, resp_valid at done+1, resp_id=0, resp_err=0.
REQ-036 Both valid continuously after reset -> grants 0,1,0,1 across four jobs; resp_id sequence 0,1,0,1; never both ready high.
REQ-037 sched_done pulsed during START and during IDLE -> ignored; response only on WAIT-state done.
REQ-038 SCHED_TIMEOUT_EN, TIMEOUT=80, sched_done held 0 -> resp_valid=1, resp_err=1 exactly 80 WAIT cycles after entry; without macro busy stays 1.
REQ-039 reset asserted 10 cycles into WAIT -> all outputs 0 next cycle, no resp_valid; next job granted to requester 0 on tie.
REQ-040 req1_block changed during WAIT of a req1 job -> sched_block unchanged until next accept.

Source files
------------

// File: rtl/sched_arbiter.sv
// Two-requester round-robin front end for the message scheduler: accepts one block at a time,
// starts the scheduler and reports completion. Optional WAIT timeout via `SCHED_TIMEOUT_EN.
module sched_arbiter #(
  parameter int unsigned TIMEOUT = 80
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         req0_valid,
  input  logic [511:0] req0_block,
  input  logic [1:0]   req0_count,
  output logic         req0_ready,
  input  logic         req1_valid,
  input  logic [511:0] req1_block,
  input  logic [1:0]   req1_count,
  output logic         req1_ready,
  output logic         sched_start,
  output logic [511:0] sched_block,
  output logic [1:0]   sched_block_count,
  input  logic         sched_done,
  output logic         resp_valid,
  output logic         resp_id,
  output logic         resp_err,
  output logic         busy
);

  if (TIMEOUT < 65 || TIMEOUT > 255) begin : g_bad_timeout
    $error("sched_arbiter: TIMEOUT must lie in 65..255");
  end

  typedef enum logic [1:0] {IDLE, START, WAIT, RESP} state_t;

  state_t state, state_next;
  logic   last_grant;
  logic   grant_id;
  logic   err_q;
  logic   any_valid;
  logic   grant_sel;
  logic   accept;
  logic   timeout_hit;

  assign any_valid = req0_valid | req1_valid;
  // On a tie the requester not granted last wins; a lone requester always wins.
  assign grant_sel = (req0_valid && req1_valid) ? ~last_grant : req1_valid;
  assign accept    = (state == IDLE) && any_valid;

`ifdef SCHED_TIMEOUT_EN
  logic [7:0] wait_cnt;

  assign timeout_hit = (state == WAIT) && (wait_cnt == 8'(TIMEOUT - 1));

  always_ff @(posedge clk) begin
    if (reset)                wait_cnt <= '0;
    else if (state == START)  wait_cnt <= '0;
    else if (state == WAIT)   wait_cnt <= wait_cnt + 8'd1;
  end
`else
  assign timeout_hit = 1'b0;
`endif

  // NOTE: every output of a combinational block gets a default first so no latch is inferred.
  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (any_valid) state_next = START;
      START:   state_next = WAIT;
      WAIT:    if (sched_done || timeout_hit) state_next = RESP;
      RESP:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update together.
  always_ff @(posedge clk) begin
    if (reset) begin
      state             <= IDLE;
      last_grant        <= 1'b1;
      grant_id          <= 1'b0;
      err_q             <= 1'b0;
      sched_block       <= '0;
      sched_block_count <= '0;
    end else begin
      state <= state_next;
      if (accept) begin
        last_grant        <= grant_sel;
        grant_id          <= grant_sel;
        sched_block       <= grant_sel ? req1_block : req0_block;
        sched_block_count <= grant_sel ? req1_count : req0_count;
      end
      // Done takes precedence over a coincident terminal count.
      if (state == WAIT && state_next == RESP) err_q <= timeout_hit && !sched_done;
    end
  end

  // Outputs are forced low while reset is held, whatever state is still registered.
  assign req0_ready  = !reset && accept && !grant_sel;
  assign req1_ready  = !reset && accept &&  grant_sel;
  assign sched_start = !reset && (state == START);
  assign resp_valid  = !reset && (state == RESP);
  assign resp_id     = resp_valid && grant_id;
  assign resp_err    = resp_valid && err_q;
  assign busy        = !reset && (state != IDLE);

endmodule

// File: tb/tb_sched_arbiter.sv
// Scoreboard bench for sched_arbiter: the driver predicts accept/start/response events into
// queues from a round-robin model; a negedge monitor pops and compares each observed event.
module tb_sched_arbiter;

  localparam int unsigned TIMEOUT = 80;

  logic         clk = 1'b0;
  logic         reset;
  logic         req0_valid, req1_valid;
  logic [511:0] req0_block, req1_block;
  logic [1:0]   req0_count, req1_count;
  logic         req0_ready, req1_ready;
  logic         sched_start;
  logic [511:0] sched_block;
  logic [1:0]   sched_block_count;
  logic         sched_done;
  logic         resp_valid, resp_id, resp_err, busy;

  sched_arbiter #(.TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .reset(reset),
    .req0_valid(req0_valid), .req0_block(req0_block), .req0_count(req0_count), .req0_ready(req0_ready),
    .req1_valid(req1_valid), .req1_block(req1_block), .req1_count(req1_count), .req1_ready(req1_ready),
    .sched_start(sched_start), .sched_block(sched_block), .sched_block_count(sched_block_count),
    .sched_done(sched_done), .resp_valid(resp_valid), .resp_id(resp_id), .resp_err(resp_err),
    .busy(busy)
  );

  always #5 clk = ~clk;

  typedef struct { int cyc; bit id; } rdy_t;
  typedef struct { int cyc; logic [511:0] blk; logic [1:0] cnt; } st_t;
  typedef struct { int cyc; bit id; bit err; logic [511:0] blk; logic [1:0] cnt; } rsp_t;

  rdy_t ready_q[$];
  st_t  start_q[$];
  rsp_t resp_q[$];

  int n_vec = 0;
  int n_err = 0;
  int cyc   = 0;
  bit model_last = 1'b1;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [511:0] act, input logic [511:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic unexpected(input string name);
    n_vec++;
    n_err++;
    $display("FAIL %s: event seen at cycle %0d with nothing expected", name, cyc);
  endtask

  // Monitor: every observed output event must match the head of its queue.
  rdy_t m_r;
  st_t  m_s;
  rsp_t m_p;
  always @(negedge clk) begin
    if (!reset) begin
      if (req0_ready || req1_ready) begin
        check("ready_exclusive", 512'(req0_ready & req1_ready), 512'd0);
        if (ready_q.size() == 0) unexpected("ready");
        else begin
          m_r = ready_q.pop_front();
          check("ready_cycle", 512'(cyc), 512'(m_r.cyc));
          check("ready_id", 512'(req1_ready), 512'(m_r.id));
        end
      end
      if (sched_start) begin
        if (start_q.size() == 0) unexpected("sched_start");
        else begin
          m_s = start_q.pop_front();
          check("start_cycle", 512'(cyc), 512'(m_s.cyc));
          check("start_block", sched_block, m_s.blk);
          check("start_count", 512'(sched_block_count), 512'(m_s.cnt));
        end
      end
      if (resp_valid) begin
        if (resp_q.size() == 0) unexpected("resp_valid");
        else begin
          m_p = resp_q.pop_front();
          check("resp_cycle", 512'(cyc), 512'(m_p.cyc));
          check("resp_id", 512'(resp_id), 512'(m_p.id));
          check("resp_err", 512'(resp_err), 512'(m_p.err));
          check("resp_block_stable", sched_block, m_p.blk);
          check("resp_count_stable", 512'(sched_block_count), 512'(m_p.cnt));
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [511:0] rand512();
    logic [511:0] v;
    for (int i = 0; i < 16; i++) v[i*32 +: 32] = $urandom;
    return v;
  endfunction

  // Reference arbitration: tie goes to whoever was not granted last.
  function automatic bit pick(input bit v0, input bit v1);
    if (v0 && v1) return !model_last;
    return v1;
  endfunction

  task automatic check_outputs_zero(input string tag);
    check({tag, "_ready0"}, 512'(req0_ready), 512'd0);
    check({tag, "_ready1"}, 512'(req1_ready), 512'd0);
    check({tag, "_start"},  512'(sched_start), 512'd0);
    check({tag, "_resp"},   512'(resp_valid), 512'd0);
    check({tag, "_id"},     512'(resp_id), 512'd0);
    check({tag, "_err"},    512'(resp_err), 512'd0);
    check({tag, "_busy"},   512'(busy), 512'd0);
  endtask

  // Issues one job in an IDLE cycle; d = WAIT cycles before sched_done (-1: never).
  task automatic run_job(input bit v0, input bit v1, input logic [511:0] b0, input logic [511:0] b1,
                         input logic [1:0] c0, input logic [1:0] c1, input int d,
                         input bit noise_start, input bit chg, input bit hold);
    bit g;
    int t;
    logic [511:0] bg;
    logic [1:0] cg;
    g  = pick(v0, v1);
    model_last = g;
    bg = g ? b1 : b0;
    cg = g ? c1 : c0;
    t  = cyc;
    req0_valid = v0; req1_valid = v1;
    req0_block = b0; req1_block = b1;
    req0_count = c0; req1_count = c1;
    ready_q.push_back('{t, g});
    start_q.push_back('{t + 1, bg, cg});
`ifdef SCHED_TIMEOUT_EN
    if (d < 0) resp_q.push_back('{t + 2 + TIMEOUT, g, 1'b1, bg, cg});
    else       resp_q.push_back('{t + 3 + d, g, 1'b0, bg, cg});
`else
    resp_q.push_back('{t + 3 + (d < 0 ? 100 : d), g, 1'b0, bg, cg});
`endif
    tick();                                   // START
    if (!hold) begin req0_valid = 1'b0; req1_valid = 1'b0; end
    if (chg) begin req0_block = rand512(); req1_block = rand512(); req1_count = 2'($urandom); end
    sched_done = noise_start;
    tick();                                   // first WAIT cycle
    sched_done = 1'b0;
    if (chg) begin req1_block = rand512(); req0_count = 2'($urandom); end
    if (d < 0) begin
`ifdef SCHED_TIMEOUT_EN
      repeat (TIMEOUT) tick();                // now in RESP
`else
      repeat (100) begin
        check("wait_busy_held", 512'(busy), 512'd1);
        tick();
      end
      sched_done = 1'b1;
      tick();
      sched_done = 1'b0;
`endif
    end else begin
      repeat (d) tick();
      sched_done = 1'b1;
      tick();                                 // RESP
      sched_done = 1'b0;
    end
    tick();                                   // back in IDLE
  endtask

  task automatic idle_gap(input bit noise);
    sched_done = noise;
    tick();
    sched_done = 1'b0;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    req0_valid = 1'b1; req1_valid = 1'b1; sched_done = 1'b1;
    #1 check_outputs_zero("in_reset");
    tick();
    check_outputs_zero("reset_held");
    check("reset_block", sched_block, 512'd0);
    check("reset_count", 512'(sched_block_count), 512'd0);
    req0_valid = 1'b0; req1_valid = 1'b0; sched_done = 1'b0;
    tick();
    reset = 1'b0;
    model_last = 1'b1;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [511:0] blk;
    reset = 1'b1;
    req0_valid = 1'b0; req1_valid = 1'b0; sched_done = 1'b0;
    req0_block = '0; req1_block = '0; req0_count = '0; req1_count = '0;
    tick();
    do_reset();

    // Single requester, standard padded block, done 64 cycles after sched_start.
    blk = '0;
    blk[511:480] = 32'h61626380;
    blk[31:0]    = 32'h00000018;
    run_job(1'b1, 1'b0, blk, '0, 2'd1, 2'd0, 63, 1'b0, 1'b0, 1'b0);

    // Done pulses in IDLE and START are ignored.
    idle_gap(1'b1);
    run_job(1'b0, 1'b1, rand512(), rand512(), 2'd2, 2'd3, 4, 1'b1, 1'b0, 1'b0);

    // Both requesters held valid across four jobs after reset: 0,1,0,1.
    do_reset();
    for (int i = 0; i < 4; i++)
      run_job(1'b1, 1'b1, rand512(), rand512(), 2'($urandom), 2'($urandom),
              int'($urandom_range(0, 5)), 1'b0, 1'b0, i != 3);

    // Requester 1 changes its block while its job waits.
    run_job(1'b0, 1'b1, rand512(), rand512(), 2'd1, 2'd2, 8, 1'b0, 1'b1, 1'b0);

    // Scheduler never finishes: timeout abort, or busy held when no timeout exists.
    run_job(1'b1, 1'b0, rand512(), rand512(), 2'd3, 2'd0, -1, 1'b0, 1'b0, 1'b0);

    // Reset ten cycles into WAIT abandons the job, then requester 0 wins the first tie.
    begin
      bit g;
      int t;
      g = pick(1'b1, 1'b0);
      model_last = g;
      t = cyc;
      req0_valid = 1'b1; req0_block = rand512(); req0_count = 2'd2;
      ready_q.push_back('{t, g});
      start_q.push_back('{t + 1, req0_block, req0_count});
      tick();
      req0_valid = 1'b0;
      repeat (11) tick();
      do_reset();
      run_job(1'b1, 1'b1, rand512(), rand512(), 2'd1, 2'd1, 3, 1'b0, 1'b0, 1'b0);
    end

    // Randomized traffic.
    for (int i = 0; i < 24; i++) begin
      int v;
      v = int'($urandom_range(1, 3));
      if ($urandom_range(0, 3) == 0) idle_gap(1'($urandom));
      run_job(v[0], v[1], rand512(), rand512(), 2'($urandom), 2'($urandom),
              int'($urandom_range(0, 12)), 1'($urandom), 1'($urandom), 1'b0);
    end

    repeat (5) tick();
    check("ready_q_drained", 512'(ready_q.size()), 512'd0);
    check("start_q_drained", 512'(start_q.size()), 512'd0);
    check("resp_q_drained",  512'(resp_q.size()), 512'd0);
    check("final_busy", 512'(busy), 512'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
